// File: rtl/pd_rx_arbiter.sv
// Round-robin admission of N_REQ optical requesters into one fixed-latency photodetector,
// gated by downstream receive credits, with a source-tag pipeline aligned to the detector output.
module pd_rx_arbiter #(
    parameter int N_REQ   = 4,
    parameter int DELAY   = 2,
    parameter int CREDITS = 4,
    parameter int DW      = 8,
    localparam int SW     = $clog2(N_REQ),
    localparam int CW     = $clog2(CREDITS + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ-1:0][DW-1:0]  req_data,
    output logic [N_REQ-1:0]          req_ready,
    output logic [DW-1:0]             pd_in_data,
    output logic                      pd_in_valid,
    input  logic [DW-1:0]             pd_out_data,
    input  logic                      pd_out_valid,
    output logic [DW-1:0]             rx_data,
    output logic                      rx_valid,
    output logic [SW-1:0]             rx_src,
    input  logic                      credit_return,
    output logic [CW-1:0]             credits,
    output logic                      busy,
    output logic                      err
);

    localparam logic [CW-1:0] CREDITS_FULL = CW'(CREDITS);

    logic [SW-1:0] last;
    logic          win_found;
    logic [SW-1:0] win_idx;
    logic          accept;
    logic          credit_overflow;
    logic          delay_mismatch;

    logic          tag_valid [0:DELAY];
    logic [SW-1:0] tag_src   [0:DELAY];

    // Walk downward from the lowest priority so the nearest index after last wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            if (req_valid[(int'(last) + k) % N_REQ]) begin
                win_found = 1'b1;
                win_idx   = SW'((int'(last) + k) % N_REQ);
            end
        end
    end

    assign accept = win_found && (credits != '0);

    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[win_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last        <= SW'(N_REQ - 1);
            pd_in_valid <= 1'b0;
            pd_in_data  <= '0;
        end else begin
            pd_in_valid <= accept;
            if (accept) begin
                last       <= win_idx;
                pd_in_data <= req_data[win_idx];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k <= DELAY; k++) begin
                tag_valid[k] <= 1'b0;
                tag_src[k]   <= '0;
            end
        end else begin
            tag_valid[0] <= accept;
            tag_src[0]   <= accept ? win_idx : '0;
            for (int k = 1; k <= DELAY; k++) begin
                tag_valid[k] <= tag_valid[k-1];
                tag_src[k]   <= tag_src[k-1];
            end
        end
    end

    assign rx_data  = pd_out_data;
    assign rx_valid = pd_out_valid;
    assign rx_src   = tag_src[DELAY];

    assign credit_overflow = credit_return && !accept && (credits == CREDITS_FULL);
    assign delay_mismatch  = (pd_out_valid != tag_valid[DELAY]);

    // A return that coincides with an accept cancels out, including at full credits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            credits <= CREDITS_FULL;
        end else if (accept && !credit_return) begin
            credits <= credits - 1'b1;
        end else if (credit_return && !accept && (credits != CREDITS_FULL)) begin
            credits <= credits + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err <= 1'b0;
        end else if (credit_overflow || delay_mismatch) begin
            err <= 1'b1;
        end
    end

    always_comb begin
        busy = pd_in_valid;
        for (int k = 0; k <= DELAY; k++) begin
            busy = busy | tag_valid[k];
        end
    end

endmodule

// File: doc/pd_rx_arbiter.md
# pd_rx_arbiter

Round-robin arbiter and credit controller that shares one photodetector pipeline (fixed latency `DELAY`, no backpressure) between `N_REQ` optical requesters. It sits between the waveguide/wavelength drop ports and the photodetector. It admits at most one packet per cycle and only when the downstream receive buffer has a free credit. It tags each admitted packet with its source index so the photodetector output is delivered together with its requester ID.

## Interface
- `N_REQ`, default 4: number of requesters, ≥2.
- `DELAY`, default 2: photodetector latency in cycles. Must equal the instantiated photodetector `DELAY`.
- `CREDITS`, default 4: downstream receive-buffer slots, ≥1.
- `SW = $clog2(N_REQ)`: source-index width. Derived, not overridable.
- `clk` in 1: clock.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in N_REQ: per-requester packet valid.
- `req_data` in packet_t[N_REQ]: per-requester packet.
- `req_ready` out N_REQ: per-requester accept, one-hot or zero.
- `pd_in_data` out packet_t: to photodetector `in_data`.
- `pd_in_valid` out 1: to photodetector `in_valid`.
- `pd_out_data` in packet_t: from photodetector `out_data`.
- `pd_out_valid` in 1: from photodetector `out_valid`.
- `rx_data` out packet_t: delivered packet.
- `rx_valid` out 1: delivered-packet valid.
- `rx_src` out SW: requester index of `rx_data`.
- `credit_return` in 1: downstream frees one slot, one pulse per slot.
- `credits` out $clog2(CREDITS+1): current free credits.
- `busy` out 1: any packet is in flight in the arbiter register or the photodetector.
- `err` out 1: sticky protocol-error flag.

## Operation
- **Grant selection**
  - Round-robin pointer `last` of width SW.
  - Search order is `last+1`, `last+2`, … modulo N_REQ. The first index with `req_valid` set wins.
  - `req_ready[w]=1` only if there is a winner `w` and `credits>0`. All other `req_ready` bits are 0.
  - `req_ready` is combinational from `req_valid`, `last` and `credits`.
- **Accept:** occurs when `req_valid[w] & req_ready[w]`. On accept:
  - `pd_in_data <= req_data[w]`, `pd_in_valid <= 1`.
  - Tag stage 0 is loaded with `{1, w}`.
  - `last <= w`.
  - Credit counter decrements.
- **No accept:** `pd_in_valid <= 0`, tag stage 0 valid `<= 0`, `pd_in_data` holds its value, and `last` holds.
- **Pointer rules:** the pointer advances only on accept. A requester that drops `req_valid` without being accepted does not move the pointer.
- **Tag pipeline:** `DELAY` additional shift stages follow tag stage 0, so the output tag is aligned with `pd_out_*`.
- **Delivery:**
  - `rx_data = pd_out_data`.
  - `rx_valid = pd_out_valid`.
  - `rx_src` = index field of the final tag stage.
  - All three are combinational pass-through.
- **Credit counter:** reset value is CREDITS.
  - Accept only: −1.
  - `credit_return` only: +1.
  - Both in the same cycle: unchanged.
  - `credit_return` while `credits==CREDITS`, with no accept in that cycle: counter stays at CREDITS and `err` is set.
  - Underflow is impossible by construction, because `req_ready` is gated on `credits>0`.
- **Error conditions:** `err` is set on either of the following and is cleared only by `rst`:
  - credit overflow;
  - `pd_out_valid` differing from the final tag-stage valid bit (photodetector `DELAY` mismatch).
- **busy:** OR of `pd_in_valid` and all tag-stage valid bits.

## Timing
- **Reset values:**
  - `pd_in_valid=0`, `pd_in_data=0`.
  - All tag stages = 0.
  - `last=N_REQ-1`, so requester 0 has first priority.
  - `credits=CREDITS`, `err=0`, `busy=0`.
  - `req_ready` follows `req_valid` immediately, because credits are full.
  - `rx_*` follow the photodetector, which also resets to 0.
- **Latency:** an accept in cycle T gives `pd_in_valid` in T+1 and `rx_valid` in T+1+DELAY.
- **Throughput:** one packet per cycle while credits last.
- **Credit timing:**
  - A credit returned in cycle T is usable for an accept in T+1.
  - With CREDITS slots and no return, exactly CREDITS back-to-back accepts occur, then `req_ready` is all zero.
- **Reset mid-operation:** all in-flight packets and tags are discarded, with no `rx_valid` afterwards. Credits return to CREDITS and the downstream buffer is reset by the same `rst`.

## Test plan
- **Single requester:** req 2 valid alone with data 0xA5 in cycle 0 → `req_ready=4'b0100` in cycle 0. With DELAY=2, `pd_in_valid` is high in cycle 1, and `rx_valid=1`, `rx_data=0xA5`, `rx_src=2` in cycle 3. `credits` 4→3.
- **Round-robin fairness:** all 4 requesters held valid, `credit_return` every cycle → grants 0,1,2,3,0,1 on consecutive cycles. `rx_src` shows the same sequence shifted by 3 cycles. `credits` stays at 4 after the first return.
- **Credit exhaustion:** CREDITS=4, all valid, no returns → 4 accepts, then `req_ready=0` and `credits=0`. One `credit_return` pulse → exactly one more accept on the next cycle.
- **Simultaneous accept and return:** at `credits=1` → `credits` stays 1. `credit_return` at `credits=4` with no accept → `credits` stays 4 and `err` rises and stays high.
- **Reset mid-flight:** assert `rst` one cycle after 2 accepts → no `rx_valid` afterwards, `busy=0`, `credits=4`, `err=0`. The next accept goes to requester 0.
- **DELAY mismatch:** photodetector instantiated with DELAY=3 while the arbiter uses 2 → `err` is set on the first packet.
